div_sched_ctrl: RTL and testbench

- Schedules the shared iterative RV32M divider for the in-order pipeline.
- Accepts a divide/remainder from the E stage and launches the divider.
- Lets independent instructions keep flowing; stalls decode only on hazards against the pending result.
- Arbitrates the single register-file write port with the W stage to write the result back.

---
 rtl/div_sched_pkg.sv | 30 +++
 rtl/div_sched_ctrl_hazard.sv | 32 +++
 rtl/div_sched_ctrl.sv | 134 +++++++++++++
 tb/tb_div_sched_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// Shared definitions for the RV32M divider scheduler: state encoding,
// divide/remainder func3 codes and the countdown-width helper.
package div_sched_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      BUSY = ST_BUSY,
      DONE = ST_DONE
   } state_t;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   // Bits needed to hold DIV_LAT-1; never less than one.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned w;
      w = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) w = i + 1;
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/div_sched_ctrl_hazard.sv
// Decode-stage hazard check against the pending divide result:
// structural (second divide), RAW on rs1/rs2 and WAW on rd.
module div_sched_hazard
   import div_sched_pkg::*;
(
   input  logic       i_pend,
   input  logic [4:0] i_prd,
   input  logic       i_div_active,
   input  logic       i_d_is_div,
   input  logic       i_d_use_rs1,
   input  logic [4:0] i_d_rs1,
   input  logic       i_d_use_rs2,
   input  logic [4:0] i_d_rs2,
   input  logic       i_d_wreg,
   input  logic [4:0] i_d_rd,
   output logic       o_stall
);

   logic w_struct;
   logic w_raw1;
   logic w_raw2;
   logic w_waw;

   always_comb begin
      w_struct = i_d_is_div & i_div_active;
      w_raw1   = i_pend & i_d_use_rs1 & (i_d_rs1 == i_prd);
      w_raw2   = i_pend & i_d_use_rs2 & (i_d_rs2 == i_prd);
      w_waw    = i_pend & i_d_wreg    & (i_d_rd  == i_prd);
      o_stall  = w_struct | w_raw1 | w_raw2 | w_waw;
   end

endmodule

// File: rtl/div_sched_ctrl.sv
// Scheduler for the shared iterative divider: launch from E, track the
// pending result, stall decode on hazards, and steal idle write-port cycles.
// Optional macro DIV_ZERO_BYPASS_EN resolves divide-by-zero without the divider.
module div_sched_ctrl
   import div_sched_pkg::*;
#(
   parameter int unsigned DIV_LAT = 32,
   parameter int unsigned XLEN    = 32
) (
   input  logic            clk,
   input  logic            clrn,
   input  logic            estart_sdivide,
   input  logic            estart_udivide,
   input  logic            ecancel,
   input  logic [2:0]      efunc3,
   input  logic [4:0]      erd,
   input  logic [XLEN-1:0] ea,
   input  logic [XLEN-1:0] eb,
   input  logic            flush,
   input  logic [4:0]      d_rs1,
   input  logic [4:0]      d_rs2,
   input  logic            d_use_rs1,
   input  logic            d_use_rs2,
   input  logic            d_wreg,
   input  logic [4:0]      d_rd,
   input  logic            d_is_div,
   input  logic            wwreg,
   input  logic [XLEN-1:0] dv_q,
   input  logic [XLEN-1:0] dv_r,
   output logic            dv_start,
   output logic            dv_signed,
   output logic            stall_d,
   output logic            wb_div_valid,
   output logic [4:0]      wb_div_rd,
   output logic [XLEN-1:0] wb_div_data,
   output logic            busy
);

   localparam int unsigned CW = clog2(DIV_LAT);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [4:0]      r_rd;
   logic            r_rem;
   logic [XLEN-1:0] r_res;

   logic            w_accept;
   logic            w_div0;
   logic            w_done;
   logic            w_grant;
   logic            w_pend;
   logic [4:0]      w_prd;

   assign w_accept = (estart_sdivide | estart_udivide) & ~ecancel & ~flush
                     & (r_state == IDLE);

`ifdef DIV_ZERO_BYPASS_EN
   assign w_div0 = w_accept & (eb == '0);
`else
   logic w_unused;
   assign w_div0   = 1'b0;
   assign w_unused = &{1'b0, ea, eb, efunc3[2], efunc3[0]};
`endif

   assign dv_start  = w_accept & ~w_div0;
   assign dv_signed = estart_sdivide;
   assign busy      = (r_state != IDLE);

   assign w_done       = (r_state == DONE);
   assign w_grant      = w_done & ~wwreg & (r_rd != 5'd0);
   assign wb_div_valid = w_grant;
   assign wb_div_rd    = w_done ? r_rd  : '0;
   assign wb_div_data  = w_done ? r_res : '0;

   // The E-stage destination counts as pending in the accept cycle itself.
   assign w_prd  = w_accept ? erd : r_rd;
   assign w_pend = (w_accept | (busy & (r_rd != 5'd0))) & (w_prd != 5'd0);

   div_sched_hazard u_hazard (
      .i_pend       (w_pend),
      .i_prd        (w_prd),
      .i_div_active (busy | w_accept),
      .i_d_is_div   (d_is_div),
      .i_d_use_rs1  (d_use_rs1),
      .i_d_rs1      (d_rs1),
      .i_d_use_rs2  (d_use_rs2),
      .i_d_rs2      (d_rs2),
      .i_d_wreg     (d_wreg),
      .i_d_rd       (d_rd),
      .o_stall      (stall_d)
   );

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rd    <= '0;
         r_rem   <= 1'b0;
         r_res   <= '0;
      end else if (flush) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rd    <= erd;
                  r_rem   <= efunc3[1];
                  r_cnt   <= CW'(DIV_LAT - 1);
                  r_state <= BUSY;
`ifdef DIV_ZERO_BYPASS_EN
                  if (w_div0) begin
                     r_res   <= efunc3[1] ? ea : '1;
                     r_state <= DONE;
                  end
`endif
               end
            end
            BUSY: begin
               if (r_cnt == '0) begin
                  r_res   <= r_rem ? dv_r : dv_q;
                  r_state <= DONE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            DONE: begin
               if (w_grant || (r_rd == 5'd0)) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Directed self-checking bench for div_sched_ctrl with a fixed-latency
// divider model that presents its result only in the capture cycle.
module tb_div_sched_ctrl;
   import div_sched_pkg::*;

   localparam int unsigned DIV_LAT = 32;
   localparam int unsigned XLEN    = 32;

   logic            clk = 1'b0;
   logic            clrn;
   logic            estart_sdivide, estart_udivide, ecancel, flush;
   logic [2:0]      efunc3;
   logic [4:0]      erd, d_rs1, d_rs2, d_rd;
   logic [XLEN-1:0] ea, eb, dv_q, dv_r;
   logic            d_use_rs1, d_use_rs2, d_wreg, d_is_div, wwreg;
   logic            dv_start, dv_signed, stall_d, wb_div_valid, busy;
   logic [4:0]      wb_div_rd;
   logic [XLEN-1:0] wb_div_data;

   int tests = 0;
   int fails = 0;

   div_sched_ctrl #(.DIV_LAT(DIV_LAT), .XLEN(XLEN)) dut (
      .clk(clk), .clrn(clrn),
      .estart_sdivide(estart_sdivide), .estart_udivide(estart_udivide),
      .ecancel(ecancel), .efunc3(efunc3), .erd(erd), .ea(ea), .eb(eb),
      .flush(flush), .d_rs1(d_rs1), .d_rs2(d_rs2),
      .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2), .d_wreg(d_wreg),
      .d_rd(d_rd), .d_is_div(d_is_div), .wwreg(wwreg),
      .dv_q(dv_q), .dv_r(dv_r), .dv_start(dv_start), .dv_signed(dv_signed),
      .stall_d(stall_d), .wb_div_valid(wb_div_valid), .wb_div_rd(wb_div_rd),
      .wb_div_data(wb_div_data), .busy(busy)
   );

   always #5 clk = ~clk;

   // Divider model: result valid only DIV_LAT cycles after the launch cycle.
   logic [XLEN-1:0] m_a = '0;
   logic [XLEN-1:0] m_b = '0;
   int              m_cnt = 0;
   always @(posedge clk) begin
      if (dv_start) begin
         m_a   <= ea;
         m_b   <= eb;
         m_cnt <= DIV_LAT;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
      end
   end
   assign dv_q = (m_cnt == 1) ? ((m_b == '0) ? '1  : m_a / m_b) : 32'hDEAD_BEEF;
   assign dv_r = (m_cnt == 1) ? ((m_b == '0) ? m_a : m_a % m_b) : 32'hBAD0_BAD0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      estart_sdivide = 0; estart_udivide = 0; ecancel = 0; flush = 0;
      efunc3 = '0; erd = '0; ea = '0; eb = '0;
      d_rs1 = '0; d_rs2 = '0; d_use_rs1 = 0; d_use_rs2 = 0;
      d_wreg = 0; d_rd = '0; d_is_div = 0; wwreg = 0;
   endtask

   task automatic start(input logic sgn, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
      estart_sdivide = sgn; estart_udivide = ~sgn;
      efunc3 = f3; erd = rd; ea = a; eb = b;
   endtask

   task automatic clear_e();
      estart_sdivide = 0; estart_udivide = 0; flush = 0; ecancel = 0;
   endtask

   initial begin
      logic seen;
      logic [31:0] exp_res;
      idle_inputs();
      clrn = 0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_valid", wb_div_valid, 0);
      chk("rst_rd", wb_div_rd, 0);
      chk("rst_data", wb_div_data, 0);
      chk("rst_stall", stall_d, 0);
      chk("rst_start", dv_start, 0);
      clrn = 1;

      // divu 100/7 -> x5 = 14
      tick(); start(0, F3_DIVU, 5, 100, 7); #1;
      chk("divu_start", dv_start, 1);
      chk("divu_signed", dv_signed, 0);
      chk("divu_busy_T", busy, 0);
      for (int k = 1; k <= 32; k++) begin
         tick(); clear_e(); #1;
         chk("divu_busy", busy, 1);
         chk("divu_novalid", wb_div_valid, 0);
         if (k == 1) chk("divu_pulse", dv_start, 0);
      end
      tick(); #1;
      chk("divu_valid", wb_div_valid, 1);
      chk("divu_rd", wb_div_rd, 5);
      chk("divu_data", wb_div_data, 14);
      tick(); #1;
      chk("divu_idle", busy, 0);
      chk("divu_vclr", wb_div_valid, 0);
      chk("divu_dclr", wb_div_data, 0);

      // remu 100/7 with decode reading x5: stall through the grant cycle
      tick(); start(0, F3_REMU, 5, 100, 7); d_use_rs1 = 1; d_rs1 = 5; #1;
      chk("raw_stall_T", stall_d, 1);
      for (int k = 1; k <= 33; k++) begin
         tick(); clear_e(); #1;
         chk("raw_stall", stall_d, 1);
         if (k == 33) begin
            chk("remu_valid", wb_div_valid, 1);
            chk("remu_data", wb_div_data, 2);
         end
      end
      tick(); #1;
      chk("raw_release", stall_d, 0);
      chk("raw_idle", busy, 0);
      idle_inputs();

      // independent decode; WAW at k=5, rs2 RAW at k=7, second div from k=11
      tick(); start(0, F3_DIVU, 5, 100, 7);
      d_use_rs1 = 1; d_rs1 = 3; d_use_rs2 = 1; d_rs2 = 4; d_wreg = 1; d_rd = 6; #1;
      chk("indep_T", stall_d, 0);
      for (int k = 1; k <= 33; k++) begin
         tick(); clear_e();
         d_rd     = (k == 5) ? 5'd5 : 5'd6;
         d_rs2    = (k == 7) ? 5'd5 : 5'd4;
         d_is_div = (k >= 11);
         #1;
         chk("indep_stall", stall_d, (k == 5) || (k == 7) || (k >= 11));
         if (k == 33) chk("indep_data", wb_div_data, 14);
      end
      tick(); #1;
      chk("struct_release", stall_d, 0);
      idle_inputs();

      // W stage holds the port for 3 DONE cycles: 1000/10 -> x9 = 100
      tick(); start(0, F3_DIVU, 9, 1000, 10); #1;
      for (int k = 1; k <= 32; k++) begin
         tick(); clear_e(); #1;
      end
      for (int j = 0; j < 3; j++) begin
         tick(); wwreg = 1; #1;
         chk("wwreg_block", wb_div_valid, 0);
         chk("wwreg_data", wb_div_data, 100);
         chk("wwreg_rd", wb_div_rd, 9);
         chk("wwreg_busy", busy, 1);
      end
      tick(); wwreg = 0; #1;
      chk("wwreg_grant", wb_div_valid, 1);
      chk("wwreg_gdata", wb_div_data, 100);
      tick(); #1;
      chk("wwreg_idle", busy, 0);

      // flush at T+10 kills the divide
      tick(); start(0, F3_DIVU, 5, 100, 7); #1;
      for (int k = 1; k <= 10; k++) begin
         tick(); clear_e(); flush = (k == 10); #1;
         if (k == 10) chk("flush_busy", busy, 1);
      end
      tick(); flush = 0; #1;
      chk("flush_idle", busy, 0);
      seen = 0;
      for (int k = 0; k < 30; k++) begin
         tick(); #1;
         if (wb_div_valid) seen = 1;
      end
      chk("flush_nowb", seen, 0);

      // flush beats a same-cycle start; ecancel suppresses launch
      tick(); start(0, F3_DIVU, 5, 100, 7); flush = 1; #1;
      chk("flush_acc", dv_start, 0);
      tick(); clear_e(); #1;
      chk("flush_acc_idle", busy, 0);
      tick(); start(1, F3_DIV, 5, 100, 7); ecancel = 1; #1;
      chk("cancel_start", dv_start, 0);
      tick(); clear_e(); #1;
      chk("cancel_idle", busy, 0);

      // async reset mid-divide
      tick(); start(0, F3_DIVU, 5, 100, 7); #1;
      for (int k = 1; k <= 5; k++) begin
         tick(); clear_e(); #1;
      end
      d_use_rs1 = 1; d_rs1 = 5;
      clrn = 0; #1;
      chk("arst_busy", busy, 0);
      chk("arst_stall", stall_d, 0);
      chk("arst_valid", wb_div_valid, 0);
      chk("arst_rd", wb_div_rd, 0);
      chk("arst_data", wb_div_data, 0);
      tick(); clrn = 1; idle_inputs();
      #1;
      chk("arst_after", busy, 0);

      // rd = x0: no pending hazard, no grant, DONE drops straight to IDLE
      tick(); start(0, F3_DIVU, 0, 100, 7); d_use_rs1 = 1; d_rs1 = 0; #1;
      chk("x0_stall", stall_d, 0);
      for (int k = 1; k <= 32; k++) begin
         tick(); clear_e(); #1;
      end
      tick(); #1;
      chk("x0_novalid", wb_div_valid, 0);
      chk("x0_done", busy, 1);
      tick(); #1;
      chk("x0_idle", busy, 0);
      idle_inputs();

      // divide by zero: -5/0 -> all-ones, rem -> dividend
      for (int r = 0; r < 2; r++) begin
         exp_res = (r == 1) ? 32'hFFFF_FFFB : 32'hFFFF_FFFF;
         tick(); start(1, (r == 1) ? F3_REM : F3_DIV, 7, 32'hFFFF_FFFB, 0); #1;
`ifdef DIV_ZERO_BYPASS_EN
         chk("dz_nostart", dv_start, 0);
         tick(); clear_e(); #1;
`else
         chk("dz_start", dv_start, 1);
         chk("dz_signed", dv_signed, 1);
         for (int k = 1; k <= 33; k++) begin
            tick(); clear_e(); #1;
         end
`endif
         chk("dz_valid", wb_div_valid, 1);
         chk("dz_data", wb_div_data, exp_res);
         tick(); #1;
         chk("dz_idle", busy, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
